// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the DE10-Lite button/switch input conditioner.
package input_cond_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int SYNC_STAGES_DEFAULT     = 2;
  localparam int PRESS_CNT_W             = 8;

  localparam logic BTN_IDLE = 1'b1;
  localparam logic SW_IDLE  = 1'b0;

  // Width of a counter that must be able to hold the value 'cycles'.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side bundle of the input conditioner: raw pins in, debounced levels and press events out.
interface input_conditioner_if #(
  parameter int N_BTN = 2,
  parameter int N_SW  = 10
);

  logic [N_BTN-1:0]   btn_raw;
  logic [N_SW-1:0]    sw_raw;
  logic [N_BTN-1:0]   button_out;
  logic [N_SW-1:0]    switch_out;
  logic [N_BTN-1:0]   btn_press_pulse;
  logic [8*N_BTN-1:0] btn_press_cnt;

  modport master (
    output btn_raw,
    output sw_raw,
    input  button_out,
    input  switch_out,
    input  btn_press_pulse,
    input  btn_press_cnt
  );

  modport slave (
    input  btn_raw,
    input  sw_raw,
    output button_out,
    output switch_out,
    output btn_press_pulse,
    output btn_press_cnt
  );

endinterface

// File: rtl/input_conditioner_debounce_bit.sv
// One input bit: SYNC_STAGES-deep synchronizer, stability counter and debounced stable register.
// o_update flags the cycle whose rising edge commits a new stable value; it depends on flops only.
module debounce_bit
  import input_cond_pkg::*;
#(
  parameter int   SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic i_raw,
  output logic o_stable,
  output logic o_update
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stable;
  logic [CW-1:0]          r_cnt;
  logic                   w_sync;
  logic                   w_differ;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_differ = (w_sync != r_stable);
  assign o_update = w_differ && (r_cnt == LAST);
  assign o_stable = r_stable;

  // Any cycle where the synchronized level matches the stable one restarts the window.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync   <= {SYNC_STAGES{RESET_VALUE}};
      r_stable <= RESET_VALUE;
      r_cnt    <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_stable <= w_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Debounces DE10-Lite buttons (active-low) and switches ahead of the CPU PIOs.
// Build macro INPUT_COND_PRESS_EVENT_EN adds per-button press pulses and wrapping 8-bit press counters.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int N_SW            = 10,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input_conditioner_if.slave  pins
);

  logic [N_BTN-1:0] w_btn_stable;
  logic [N_BTN-1:0] w_btn_update;
  logic [N_SW-1:0]  w_sw_stable;
  logic [N_SW-1:0]  w_sw_update_unused;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (BTN_IDLE)
    ) u_db (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .i_raw       (pins.btn_raw[gi]),
      .o_stable    (w_btn_stable[gi]),
      .o_update    (w_btn_update[gi])
    );
  end

  for (genvar gs = 0; gs < N_SW; gs++) begin : g_sw
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (SW_IDLE)
    ) u_db (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .i_raw       (pins.sw_raw[gs]),
      .o_stable    (w_sw_stable[gs]),
      .o_update    (w_sw_update_unused[gs])
    );
  end

  assign pins.button_out = w_btn_stable;
  assign pins.switch_out = w_sw_stable;

`ifdef INPUT_COND_PRESS_EVENT_EN
  logic [N_BTN-1:0]             r_press_pulse;
  logic [PRESS_CNT_W*N_BTN-1:0] r_press_cnt;
  logic [N_BTN-1:0]             w_press;

  // A commit while the stable level is still high is exactly the 1->0 edge,
  // so the pulse lands on the same clock edge that button_out falls.
  assign w_press = w_btn_update & w_btn_stable;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_press_pulse <= '0;
      r_press_cnt   <= '0;
    end else begin
      r_press_pulse <= w_press;
      for (int i = 0; i < N_BTN; i++) begin
        if (w_press[i]) begin
          r_press_cnt[PRESS_CNT_W*i +: PRESS_CNT_W] <=
            r_press_cnt[PRESS_CNT_W*i +: PRESS_CNT_W] + 1'b1;
        end
      end
    end
  end

  assign pins.btn_press_pulse = r_press_pulse;
  assign pins.btn_press_cnt   = r_press_cnt;
`else
  logic w_press_unused;

  assign w_press_unused       = ^w_btn_update;
  assign pins.btn_press_pulse = '0;
  assign pins.btn_press_cnt   = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=8): expected output
// snapshots are queued with their due cycle when stimulus is driven and checked every cycle.
module tb_input_conditioner;
  import input_cond_pkg::*;

  localparam int NB  = 2;
  localparam int NS  = 10;
  localparam int LAT = 2 + 8;

  typedef logic [29:0] snap_t;
  typedef struct {
    int    due;
    snap_t snap;
  } ev_t;

  localparam snap_t RST_SNAP = {2'b11, 10'h000, 2'b00, 16'h0000};

  logic clk_clk     = 1'b0;
  logic reset_reset = 1'b1;
  int   cyc         = 0;
  int   n_assert    = 0;
  int   n_fail      = 0;
  bit   mon_en      = 1'b0;

  ev_t         q[$];
  snap_t       cur;
  logic [1:0]  e_btn;
  logic [9:0]  e_sw;
  logic [15:0] e_cnt;

  input_conditioner_if #(.N_BTN(NB), .N_SW(NS)) ifc ();

  input_conditioner #(
    .N_BTN           (NB),
    .N_SW            (NS),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .pins        (ifc.slave)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  function automatic snap_t snap();
    return {ifc.button_out, ifc.switch_out, ifc.btn_press_pulse, ifc.btn_press_cnt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  // Queue the output snapshot expected once new raw levels (driven now) have been debounced.
  task automatic sched(input int due, input logic [1:0] nb, input logic [9:0] ns);
    ev_t ev;
`ifdef INPUT_COND_PRESS_EVENT_EN
    logic [1:0] pressed;
    pressed = e_btn & ~nb;
    for (int i = 0; i < NB; i++)
      if (pressed[i]) e_cnt[8*i +: 8] = e_cnt[8*i +: 8] + 8'd1;
    e_btn   = nb;
    e_sw    = ns;
    ev.due  = due;
    ev.snap = {e_btn, e_sw, pressed, e_cnt};
    q.push_back(ev);
    if (pressed != 2'b00) begin
      ev.due  = due + 1;
      ev.snap = {e_btn, e_sw, 2'b00, e_cnt};
      q.push_back(ev);
    end
`else
    e_btn   = nb;
    e_sw    = ns;
    ev.due  = due;
    ev.snap = {e_btn, e_sw, 2'b00, e_cnt};
    q.push_back(ev);
`endif
  endtask

  task automatic apply_reset(input int n, input string tag);
    mon_en      = 1'b0;
    reset_reset = 1'b1;
    tick(1);
    check({tag, "_first_edge"}, 32'(snap()), 32'(RST_SNAP));
    tick(n - 1);
    check({tag, "_held"}, 32'(snap()), 32'(RST_SNAP));
  endtask

  task automatic release_reset();
    reset_reset = 1'b0;
    e_btn       = 2'b11;
    e_sw        = '0;
    e_cnt       = '0;
    cur         = RST_SNAP;
    mon_en      = 1'b1;
  endtask

  always @(negedge clk_clk) begin : monitor
    ev_t ev;
    if (mon_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        ev  = q.pop_front();
        cur = ev.snap;
        check("event", 32'(snap()), 32'(cur));
      end else begin
        check("steady", 32'(snap()), 32'(cur));
      end
    end
  end

  initial begin
    logic [9:0] sw_v;

    // Reset with random pins
    ifc.btn_raw = 2'($urandom);
    ifc.sw_raw  = 10'($urandom);
    apply_reset(3, "reset");
    ifc.btn_raw = 2'b11;
    ifc.sw_raw  = '0;
    release_reset();
    tick(5);

    // Clean press and release of button 0
    ifc.btn_raw[0] = 1'b0;
    sched(cyc + LAT, 2'b10, e_sw);
    tick(20);
    ifc.btn_raw[0] = 1'b1;
    sched(cyc + LAT, 2'b11, e_sw);
    tick(20);
    check("q_empty_clean", q.size(), 0);

    // Bounce on button 1, then settle pressed
    for (int k = 0; k < 10; k++) begin
      ifc.btn_raw[1] = k[0];
      tick(3);
    end
    ifc.btn_raw[1] = 1'b0;
    sched(cyc + LAT, 2'b01, e_sw);
    tick(20);
    ifc.btn_raw[1] = 1'b1;
    sched(cyc + LAT, 2'b11, e_sw);
    tick(20);
    check("q_empty_bounce", q.size(), 0);

    // Switch glitches: 7 cycles rejected, 8 cycles accepted (and later returns)
    ifc.sw_raw[5] = 1'b1;
    tick(7);
    ifc.sw_raw[5] = 1'b0;
    tick(20);
    ifc.sw_raw[5] = 1'b1;
    sw_v = 10'h020;
    sched(cyc + LAT, e_btn, sw_v);
    tick(8);
    ifc.sw_raw[5] = 1'b0;
    sched(cyc + LAT, e_btn, 10'h000);
    tick(20);

    // Multi-bit switch patterns
    ifc.sw_raw = 10'h2A5;
    sched(cyc + LAT, e_btn, 10'h2A5);
    tick(15);
    ifc.sw_raw = 10'h15A;
    sched(cyc + LAT, e_btn, 10'h15A);
    tick(15);
    ifc.sw_raw = 10'h000;
    sched(cyc + LAT, e_btn, 10'h000);
    tick(15);
    check("q_empty_switch", q.size(), 0);

    // Simultaneous presses from a fresh reset; counters wrap back to 0
    apply_reset(2, "reset_pre_wrap");
    release_reset();
    tick(2);
    for (int p = 0; p < 256; p++) begin
      ifc.btn_raw = 2'b00;
      sched(cyc + LAT, 2'b00, e_sw);
      tick(12);
      ifc.btn_raw = 2'b11;
      sched(cyc + LAT, 2'b11, e_sw);
      tick(12);
    end
    check("wrap_cnt_zero", 32'(ifc.btn_press_cnt), 32'h0);
    check("q_empty_wrap", q.size(), 0);

    // Reset 5 cycles into a debounce window discards it
    ifc.btn_raw[0] = 1'b0;
    tick(5);
    apply_reset(2, "reset_mid");
    release_reset();
    sched(cyc + LAT, 2'b10, e_sw);
    tick(20);
    ifc.btn_raw[0] = 1'b1;
    sched(cyc + LAT, 2'b11, e_sw);
    tick(20);
    check("q_empty_final", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Conditions the raw DE10-Lite push-button and slide-switch pins before they reach the button and switch PIO ports of the embedded CPU system. The block sits directly upstream of those PIOs. Each input bit passes through a synchronizer and then a per-bit debounce filter. Optionally, the block also produces one-cycle press pulses and wrapping press counters for the buttons. It runs entirely in the system clock domain.

## Interface
Parameters:
- N_BTN, default 2: number of push-buttons (active-low pins).
- N_SW, default 10: number of slide switches (active-high).
- SYNC_STAGES, default 2: synchronizer flop depth, minimum 2.
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required before an output changes (10 ms at 50 MHz). Minimum 2.

Ports:
- clk_clk  in  1  system clock, 50 MHz.
- reset_reset  in  1  synchronous reset, active-high.
- btn_raw  in  N_BTN  asynchronous button pins, 0 = pressed.
- sw_raw  in  N_SW  asynchronous switch pins.
- button_out  out  N_BTN  debounced buttons, active-low; feeds the button PIO.
- switch_out  out  N_SW  debounced switches; feeds the switch PIO.
- btn_press_pulse  out  N_BTN  one-cycle pulse per debounced press.
- btn_press_cnt  out  8*N_BTN  per-button 8-bit press count, with button i in bits [8i+7:8i].

## Operation
- Each bit has a SYNC_STAGES flop chain, then a stable register and a counter. The counter width is clog2(DEBOUNCE_CYCLES+1).
- When the synchronized value equals the stable value, the counter is cleared to 0.
- When they differ, the counter increments. On the cycle the counter equals DEBOUNCE_CYCLES-1, the stable register takes the synchronized value and the counter clears.
- Any return to the stable value before that point clears the counter. Glitches shorter than DEBOUNCE_CYCLES therefore never reach the outputs.
- button_out and switch_out are the stable registers, driven directly from flops.
- Press detection: a debounced button transition 1->0 asserts btn_press_pulse[i] for exactly one cycle. In that same edge, btn_press_cnt[i] increments.
- A release (0->1) produces no pulse and no count.
- The counters wrap from 255 to 0.
- Buttons are independent. Simultaneous presses pulse and count in the same cycle.

## Timing
- Reset values:
  - sync flops and stable registers: buttons all 1, switches all 0.
  - debounce counters: 0.
  - btn_press_pulse: 0.
  - btn_press_cnt: 0.
- Reset is synchronous, and all outputs show reset values at the first edge with reset_reset high.
- Reset during a debounce window discards it. After reset deasserts, a held input needs the full latency again.
- Latency from a raw change (held stable) to the output change: SYNC_STAGES + DEBOUNCE_CYCLES rising edges.
- btn_press_pulse rises on the same edge that button_out falls.
- No input-to-output combinational path exists.

## Configuration
- Macro INPUT_COND_PRESS_EVENT_EN.
- Defined: the press-edge detector and the 8-bit press counters are implemented as described above.
- Undefined: that logic is not built. btn_press_pulse and btn_press_cnt are tied to 0, and the ports remain present. Debounced level outputs are identical in both builds.

## Structure
- Package input_cond_pkg holds:
  - the default constants DEBOUNCE_CYCLES_DEFAULT and SYNC_STAGES_DEFAULT;
  - BTN_IDLE = 1'b1 and SW_IDLE = 1'b0;
  - a counter-width function.
- Sub-module debounce_bit contains the synchronizer, counter and stable register for a single bit. It is parameterized by SYNC_STAGES, DEBOUNCE_CYCLES and RESET_VALUE, and is instantiated N_BTN + N_SW times.
- The top level holds only the instances and the optional press logic.

## Test plan
All scenarios run with SYNC_STAGES=2, DEBOUNCE_CYCLES=8 and the macro defined unless noted.
- **Reset:** hold reset_reset for 3 cycles with raw inputs random -> button_out=2'b11, switch_out=0, pulse=0, cnt=0.
- **Clean press:** btn_raw[0] 1->0, held 20 cycles -> button_out[0] falls exactly 10 edges after the change; btn_press_pulse[0] is high for 1 cycle on that edge; btn_press_cnt[7:0]=1. On release, no pulse and cnt stays 1.
- **Bounce:** toggle btn_raw[1] every 3 cycles for 30 cycles, then hold 0 -> exactly one falling transition, 10 edges after the last toggle; exactly one pulse.
- **Glitch:** sw_raw[5]=1 for 7 cycles -> switch_out unchanged. Repeat with 8 cycles -> switch_out[5] rises 10 edges after the change.
- **Simultaneous and wrap:** press both buttons together 256 times -> pulses coincide each time, and both counters read 0 after the final press.
- **Reset mid-debounce and macro off:**
  - Assert reset 5 cycles after btn_raw[0] falls -> button_out[0] stays 1 and needs 10 full edges after reset release.
  - With the macro undefined, pulses and counts stay 0 throughout the same stimuli.
